// File: rtl/serializador_mux8_pkg.sv
// Shared types for the 8-bit serializer: FSM state encoding,
// parity mode codes and select start/end helpers.
package serializador_mux8_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    DADOS  = 2'd1,
    PAR    = 2'd2,
    FIM    = 2'd3
  } estado_t;

  // Parity mode codes (the PAR state name is taken by estado_t).
  localparam int PARID_NENHUMA = 0;
  localparam int PARID_PAR     = 1;
  localparam int PARID_IMPAR   = 2;

  function automatic logic [2:0] sel_inicial(input bit lsb);
    return lsb ? 3'd0 : 3'd7;
  endfunction

  function automatic logic [2:0] sel_final(input bit lsb);
    return lsb ? 3'd7 : 3'd0;
  endfunction

endpackage

// File: rtl/serializador_mux8_mux8para1.sv
// 1-bit 8:1 multiplexer.
// Ports: i0..i7 data bits, sel 3-bit select, y selected bit.
module Mux8para1 (
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  input  logic       i4,
  input  logic       i5,
  input  logic       i6,
  input  logic       i7,
  input  logic [2:0] sel,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    unique case (sel)
      3'd0: y = i0;
      3'd1: y = i1;
      3'd2: y = i2;
      3'd3: y = i3;
      3'd4: y = i4;
      3'd5: y = i5;
      3'd6: y = i6;
      3'd7: y = i7;
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/serializador_mux8.sv
// Parallel-to-serial converter driving a Mux8para1 select.
// Ports: clk, rst (async high), start/dados load, aceita handshake,
//        pronto, bit_out, bit_valido, fim, sel (observation).
module serializador_mux8
  import serializador_mux8_pkg::*;
#(
  parameter int LSB_PRIMEIRO = 1,
  parameter int PARIDADE     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dados,
  input  logic       aceita,
  output logic       pronto,
  output logic       bit_out,
  output logic       bit_valido,
  output logic       fim,
  output logic [2:0] sel
);

  localparam bit LSB = (LSB_PRIMEIRO != 0);
  // Mode 3 is illegal and behaves like no parity.
  localparam bit USA_PAR = (PARIDADE == PARID_PAR) ||
                           (PARIDADE == PARID_IMPAR);
  localparam bit IMPAR = (PARIDADE == PARID_IMPAR);

  estado_t    estado_q, estado_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] palavra_q, palavra_d;
  logic       acc_q, acc_d;
  logic       mux_y;

  Mux8para1 u_mux (
    .i0  (palavra_q[0]),
    .i1  (palavra_q[1]),
    .i2  (palavra_q[2]),
    .i3  (palavra_q[3]),
    .i4  (palavra_q[4]),
    .i5  (palavra_q[5]),
    .i6  (palavra_q[6]),
    .i7  (palavra_q[7]),
    .sel (sel_q),
    .y   (mux_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q  <= OCIOSO;
      sel_q     <= 3'd0;
      palavra_q <= 8'd0;
      acc_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      sel_q     <= sel_d;
      palavra_q <= palavra_d;
      acc_q     <= acc_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    sel_d     = sel_q;
    palavra_d = palavra_q;
    acc_d     = acc_q;
    unique case (estado_q)
      OCIOSO: begin
        if (start) begin
          estado_d  = DADOS;
          palavra_d = dados;
          sel_d     = sel_inicial(LSB);
          acc_d     = 1'b0;
        end
      end
      DADOS: begin
        if (aceita) begin
          // Every data bit, including the last, feeds the parity.
          acc_d = acc_q ^ mux_y;
          // Last-bit test precedes the step, so sel never wraps.
          if (sel_q == sel_final(LSB)) begin
            estado_d = USA_PAR ? PAR : FIM;
          end else if (LSB) begin
            sel_d = sel_q + 3'd1;
          end else begin
            sel_d = sel_q - 3'd1;
          end
        end
      end
      PAR: begin
        if (aceita) estado_d = FIM;
      end
      FIM: estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  assign pronto     = (estado_q == OCIOSO);
  assign bit_valido = (estado_q == DADOS) || (estado_q == PAR);
  assign fim        = (estado_q == FIM);
  assign sel        = sel_q;

  always_comb begin
    bit_out = 1'b0;
    unique case (estado_q)
      DADOS:   bit_out = mux_y;
      PAR:     bit_out = acc_q ^ IMPAR;
      default: bit_out = 1'b0;
    endcase
  end

endmodule

// File: doc/serializador_mux8.md
# serializador_mux8

Parallel-to-serial converter that sits directly upstream of the 1-bit 8:1 multiplexer `Mux8para1`: it latches an 8-bit word, drives the multiplexer's 3-bit select through all eight positions, and presents one bit per transfer on a valid/accept handshake. An optional parity bit can follow the eight data bits. A pulse on `fim` marks the end of each word. The block feeds serial consumers such as display scanners or a serial link stage.

## Interface
- `LSB_PRIMEIRO`, default 1: 1 sends bit 0 first (sel 0→7); 0 sends bit 7 first (sel 7→0).
- `PARIDADE`, default 0: 0 = no parity bit; 1 = even-parity bit appended; 2 = odd-parity bit appended; 3 = illegal, treated as 0.
- Clock and reset: single clock `clk`, rising edge. Reset `rst` is asynchronous and active-high.
- `clk` input, 1 bit: system clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: request to load `dados`. Sampled only while `pronto`=1.
- `dados` input, 8 bits: word to serialize. Captured on the accepted `start` edge.
- `aceita` input, 1 bit: consumer accepts the current bit.
- `pronto` output, 1 bit: block is idle and can take `start`.
- `bit_out` output, 1 bit: current serial bit. Valid only when `bit_valido`=1; otherwise 0.
- `bit_valido` output, 1 bit: `bit_out` holds a bit being offered.
- `fim` output, 1 bit: one-cycle pulse after the last bit has been accepted.
- `sel` output, 3 bits: current multiplexer select (debug and observation).

## Operation
- **States:** OCIOSO, DADOS, PAR, FIM.
  - OCIOSO: `pronto`=1.
  - DADOS and PAR: `bit_valido`=1.
  - FIM: `fim`=1.
- **Transitions:**
  - OCIOSO → DADOS on `start`=1. On that edge: `dados` goes into the word register; `sel` = 0 if `LSB_PRIMEIRO` else 7; the parity accumulator is cleared.
  - DADOS, `aceita`=1, bit not last: `sel` steps +1 (LSB first) or −1 (MSB first). The accumulator XORs in the transferred bit.
  - DADOS, `aceita`=1, last bit (sel 7 for LSB first, sel 0 for MSB first): go to PAR if `PARIDADE`∈{1,2}, else go to FIM.
  - PAR: `bit_out` = accumulator XOR (`PARIDADE`==2). On `aceita`=1, go to FIM.
  - FIM → OCIOSO unconditionally after one cycle.
- **Bit source:** in DADOS, `bit_out` comes from a `Mux8para1` instance fed by the word register and `sel`.
- **Stalls:** `aceita`=0 in DADOS or PAR holds the state, `sel` and `bit_out` unchanged, indefinitely.
- **Ignored inputs:**
  - `start` outside OCIOSO is ignored. It is not queued.
  - `dados` changes after capture do not affect the word in flight.
  - `aceita` outside DADOS and PAR is ignored.
- **Select arithmetic:** 3-bit unsigned. It never wraps during a word because the last-bit test happens before the step. In OCIOSO, `sel` holds its last value.
- **Reset (including mid-word):** state goes to OCIOSO and the word is discarded. Outputs under reset: `pronto`=1, `bit_valido`=0, `bit_out`=0, `fim`=0, `sel`=0. Word register and accumulator = 0.

## Timing
- All state, `sel`, word and accumulator are registers.
- `pronto`, `bit_valido`, `fim` and `bit_out` are decoded from registers only. There is no combinational path from any input to any output.
- Latency with `aceita` tied to 1 and no parity:
  - `start` is seen at edge E0.
  - First bit is valid in cycle E0+1.
  - Bits occupy cycles E0+1 … E0+8.
  - `fim` = 1 in cycle E0+9.
  - `pronto` = 1 again in cycle E0+10.
- With parity, everything after the data bits shifts by +1 cycle (parity bit in E0+9).
- Maximum throughput: one word per 10 cycles without parity, 11 with parity.
- A bit transfers on each rising edge where `bit_valido` and `aceita` are both 1.

## Structure
- **Shared package / include file:**
  - state encodings: OCIOSO=2'd0, DADOS=2'd1, PAR=2'd2, FIM=2'd3;
  - parity mode codes: NENHUMA=0, PAR=1, IMPAR=2.
- **Sub-module:** exactly one instance of the existing `Mux8para1` (i0..i7 = word bits 0..7, sel = `sel`).
- **Top level:** FSM, select counter and parity accumulator stay in the top module.

## Test plan
- **LSB first, no parity:** `dados`=8'hA5, `aceita`=1 → `bit_out` sequence 1,0,1,0,0,1,0,1 in cycles 1–8; `fim` pulses in cycle 9; `pronto` = 1 in cycle 10.
- **MSB first, even parity:** `LSB_PRIMEIRO`=0, `PARIDADE`=1, `dados`=8'h07 → bits 0,0,0,0,0,1,1,1, then parity bit 1, then `fim`.
- **Odd parity:** `PARIDADE`=2, `dados`=8'hFF → parity bit 1. With `dados`=8'h00 → parity bit 1. With `dados`=8'h01 → parity bit 0.
- **Stall:** during a word, hold `aceita`=0 for 5 cycles at sel=3 → `sel`, `bit_out` and `bit_valido` stay frozen; the word completes correctly after release. A second `start` with 8'hFF issued mid-word is ignored, and the word in flight is unaffected.
- **Reset mid-word:** assert `rst` asynchronously at sel=4 → immediately `bit_valido`=0, `sel`=0, `pronto`=1, `fim`=0. A fresh `start` with 8'h3C then serializes 0,0,1,1,1,1,0,0.
- **Back-to-back:** assert `start` in the first cycle `pronto`=1 → the next word begins with no extra gap: 10-cycle period without parity, 11 with parity.
